// File: rtl/fcp_pkg.sv
// Shared types and constants for the FCP single-wire transmitter.
package fcp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    PARITY,
    PING
  } fcp_state_e;

  localparam logic [7:0] FCP_CRC_POLY      = 8'h07;
  localparam int         FCP_SYNC_QUARTERS = 4;

endpackage

// File: rtl/fcp_crc8_serial.sv
// Bit-serial CRC-8 (init 0x00), MSB-first; one message bit absorbed per enabled cycle.
module fcp_crc8_serial
  import fcp_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ ({8{crc[7] ^ bit_in}} & FCP_CRC_POLY);
    end
  end

endmodule

// File: rtl/fcp_tx_frame_engine.sv
// FCP frame transmitter: per byte sync + 8 data bits MSB-first + odd parity, then a ping.
// Define FCP_TX_CRC_EN to append a CRC-8 byte after the payload.
module fcp_tx_frame_engine
  import fcp_pkg::*;
#(
  parameter int UI_CYCLE  = 20,
  parameter int TUNE_W    = 8,
  parameter int CNT_W     = 10,
  parameter int MAX_BYTES = 4,
  parameter int PING_UI   = 16,
  parameter int LEN_W     = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic                   tx_ping_only,
  input  logic [LEN_W-1:0]       tx_len,
  input  logic [8*MAX_BYTES-1:0] tx_payload,
  input  logic                   tune_up,
  input  logic [TUNE_W-1:0]      tune_cycle,
  input  logic                   abort,
  output logic                   data_o,
  output logic                   busy,
  output logic                   tx_done,
  output logic                   tx_aborted
);

  // sub counts sync quarters, data bits or ping UIs depending on state
  localparam int SUB_W = ($clog2(PING_UI) > 3) ? $clog2(PING_UI) : 3;
  localparam logic signed [CNT_W+1:0] UI_MIN = (CNT_W+2)'(4);
  localparam logic signed [CNT_W+1:0] UI_MAX = (CNT_W+2)'((1 << CNT_W) - 1);

  // Extra sign bit so a large downward trim clamps to the minimum instead of wrapping.
  function automatic logic [CNT_W-1:0] tune_ui(input logic up, input logic [TUNE_W-1:0] trim);
    logic signed [CNT_W+1:0] base, delta, sum;
    base  = (CNT_W+2)'(UI_CYCLE);
    delta = (CNT_W+2)'(trim);
    sum   = up ? base + delta : base - delta;
    if (sum < UI_MIN) return CNT_W'(4);
    if (sum > UI_MAX) return CNT_W'((1 << CNT_W) - 1);
    return sum[CNT_W-1:0];
  endfunction

  fcp_state_e             state, state_nxt;
  logic [CNT_W-1:0]       ui_q, q_q, cnt, seg_len, ui_new;
  logic [SUB_W-1:0]       sub;
  logic [LEN_W-1:0]       bytes_left, len_eff;
  logic [8*MAX_BYTES-1:0] pay_q;
  logic [7:0]             shreg, cur_byte;
  logic                   aborted_q;
  logic                   accept, start_ping, seg_last;

  assign tx_ready   = (state == IDLE);
  assign busy       = !tx_ready;
  assign tx_aborted = aborted_q;
  assign accept     = tx_valid && tx_ready;
  assign start_ping = tx_ping_only || (tx_len == '0);
  assign len_eff    = (tx_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : tx_len;
  assign ui_new     = tune_ui(tune_up, tune_cycle);
  assign seg_len    = (state == SYNC) ? q_q : ui_q;
  assign seg_last   = (cnt == seg_len - CNT_W'(1));

`ifdef FCP_TX_CRC_EN
  logic       crc_phase;
  logic [7:0] crc;

  fcp_crc8_serial u_crc (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (accept),
    .en     ((state == DATA) && seg_last && !crc_phase),
    .bit_in (shreg[7]),
    .crc    (crc)
  );
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    data_o    = 1'b0;
    tx_done   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = start_ping ? PING : SYNC;
      end
      SYNC: begin
        data_o = ~sub[0];
        if (seg_last && (sub == SUB_W'(FCP_SYNC_QUARTERS - 1))) state_nxt = DATA;
      end
      DATA: begin
        data_o = shreg[7];
        if (seg_last && (sub == SUB_W'(7))) state_nxt = PARITY;
      end
      PARITY: begin
        data_o = ~^cur_byte;
        if (seg_last) begin
          if (bytes_left != '0) state_nxt = SYNC;
`ifdef FCP_TX_CRC_EN
          else                  state_nxt = crc_phase ? PING : SYNC;
`else
          else                  state_nxt = PING;
`endif
        end
      end
      PING: begin
        data_o = 1'b1;
        if (seg_last && (sub == SUB_W'(PING_UI - 1))) begin
          state_nxt = IDLE;
          tx_done   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // abort overrides everything, including completion in the final ping cycle
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      tx_done   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ui_q       <= '0;
      q_q        <= '0;
      cnt        <= '0;
      sub        <= '0;
      bytes_left <= '0;
      pay_q      <= '0;
      shreg      <= '0;
      cur_byte   <= '0;
      aborted_q  <= 1'b0;
`ifdef FCP_TX_CRC_EN
      crc_phase  <= 1'b0;
`endif
    end else begin
      aborted_q <= abort && (state != IDLE);
      if (accept) begin
        ui_q       <= ui_new;
        q_q        <= ui_new >> 2;
        cnt        <= '0;
        sub        <= '0;
        bytes_left <= len_eff - LEN_W'(1);
        pay_q      <= tx_payload >> 8;
        shreg      <= tx_payload[7:0];
        cur_byte   <= tx_payload[7:0];
`ifdef FCP_TX_CRC_EN
        crc_phase  <= 1'b0;
`endif
      end else if (state != IDLE) begin
        if (state_nxt == IDLE) begin
          cnt <= '0;
          sub <= '0;
        end else if (seg_last) begin
          cnt <= '0;
          case (state)
            SYNC: sub <= (sub == SUB_W'(FCP_SYNC_QUARTERS - 1)) ? '0 : sub + SUB_W'(1);
            DATA: begin
              shreg <= {shreg[6:0], 1'b0};
              sub   <= (sub == SUB_W'(7)) ? '0 : sub + SUB_W'(1);
            end
            PARITY: begin
              sub <= '0;
              if (bytes_left != '0) begin
                bytes_left <= bytes_left - LEN_W'(1);
                shreg      <= pay_q[7:0];
                cur_byte   <= pay_q[7:0];
                pay_q      <= pay_q >> 8;
              end
`ifdef FCP_TX_CRC_EN
              else if (!crc_phase) begin
                crc_phase <= 1'b1;
                shreg     <= crc;
                cur_byte  <= crc;
              end
`endif
            end
            PING:    sub <= sub + SUB_W'(1);
            default: sub <= '0;
          endcase
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fcp_tx_frame_engine.sv
// Scoreboard bench for fcp_tx_frame_engine: expected line waveform is run-length encoded per frame.
module tb_fcp_tx_frame_engine;

  localparam int UI_CYCLE  = 20;
  localparam int TUNE_W    = 8;
  localparam int CNT_W     = 10;
  localparam int MAX_BYTES = 4;
  localparam int PING_UI   = 16;
  localparam int LEN_W     = 3;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   tx_valid = 1'b0;
  logic                   tx_ready;
  logic                   tx_ping_only = 1'b0;
  logic [LEN_W-1:0]       tx_len = '0;
  logic [8*MAX_BYTES-1:0] tx_payload = '0;
  logic                   tune_up = 1'b0;
  logic [TUNE_W-1:0]      tune_cycle = '0;
  logic                   abort = 1'b0;
  logic                   data_o, busy, tx_done, tx_aborted;

  fcp_tx_frame_engine #(
    .UI_CYCLE(UI_CYCLE), .TUNE_W(TUNE_W), .CNT_W(CNT_W),
    .MAX_BYTES(MAX_BYTES), .PING_UI(PING_UI), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rstn(rstn), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_ping_only(tx_ping_only), .tx_len(tx_len), .tx_payload(tx_payload),
    .tune_up(tune_up), .tune_cycle(tune_cycle), .abort(abort),
    .data_o(data_o), .busy(busy), .tx_done(tx_done), .tx_aborted(tx_aborted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_bits[$];
  bit act_bits[$];
  int exp_segs[$];
  int exp_nseg[$];
  int exp_done[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  // segment encoding: level in bit 16, run length in bits 15:0
  function automatic void rle(input bit bits[$], output int segs[$]);
    segs = {};
    for (int i = 0; i < bits.size(); i++) begin
      if (i == 0 || bits[i] != bits[i-1]) segs.push_back((int'(bits[i]) << 16) | 1);
      else segs[segs.size()-1] += 1;
    end
  endfunction

  task automatic push_byte(input logic [7:0] b, input int ui, input int q);
    for (int k = 0; k < 4; k++) repeat (q) exp_bits.push_back((k % 2) == 0);
    for (int i = 7; i >= 0; i--) repeat (ui) exp_bits.push_back(b[i]);
    repeat (ui) exp_bits.push_back(~^b);
  endtask

  task automatic model_frame(input bit ping_only, input int len, input logic [31:0] pl,
                             input bit up, input int tc, input int cut);
    int ui, q, n;
    int segs[$];
    logic [7:0] b;
`ifdef FCP_TX_CRC_EN
    logic [7:0] crc;
    crc = 8'h00;
`endif
    ui = up ? UI_CYCLE + tc : UI_CYCLE - tc;
    if (ui < 4) ui = 4;
    if (ui > 1023) ui = 1023;
    q = ui / 4;
    n = (len > MAX_BYTES) ? MAX_BYTES : len;
    exp_bits.delete();
    if (!ping_only && n > 0) begin
      for (int i = 0; i < n; i++) begin
        b = pl[8*i +: 8];
        push_byte(b, ui, q);
`ifdef FCP_TX_CRC_EN
        crc = crc8_byte(crc, b);
`endif
      end
`ifdef FCP_TX_CRC_EN
      push_byte(crc, ui, q);
`endif
    end
    repeat (PING_UI * ui) exp_bits.push_back(1'b1);
    exp_done.push_back(cut > 0 ? -1 : exp_bits.size());
    if (cut > 0) while (exp_bits.size() > cut) void'(exp_bits.pop_back());
    rle(exp_bits, segs);
    exp_nseg.push_back(segs.size());
    foreach (segs[i]) exp_segs.push_back(segs[i]);
  endtask

  // Call at a negedge with the DUT idle; the request is accepted at the next posedge.
  task automatic run_frame(input string tag, input bit ping_only, input int len,
                           input logic [31:0] pl, input bit up, input int tc,
                           input bit keep, input int abort_at, output int done_at);
    int limit, n, e;
    int act_segs[$];
    bit was_aborted;
    model_frame(ping_only, len, pl, up, tc, abort_at);
    tx_ping_only = ping_only;
    tx_len       = LEN_W'(len);
    tx_payload   = pl;
    tune_up      = up;
    tune_cycle   = TUNE_W'(tc);
    tx_valid     = 1'b1;
    act_bits.delete();
    done_at     = -1;
    was_aborted = 1'b0;
    limit = exp_bits.size() + 50;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (!keep) tx_valid = 1'b0;
        chk({tag, "_busy"}, int'(busy), 1);
      end
      if (abort_at > 0 && c == abort_at + 1) begin
        chk({tag, "_abort_line"}, int'(data_o), 0);
        chk({tag, "_abort_pulse"}, int'(tx_aborted), 1);
        chk({tag, "_abort_ready"}, int'(tx_ready), 1);
        abort = 1'b0;
        was_aborted = 1'b1;
        break;
      end
      act_bits.push_back(data_o);
      if (tx_done) begin
        done_at = c;
        break;
      end
      if (abort_at > 0 && c + 1 == abort_at) begin
        @(posedge clk);
        #1 abort = 1'b1;
      end
    end
    e = exp_done.pop_front();
    chk({tag, "_done_at"}, done_at, e);
    rle(act_bits, act_segs);
    n = exp_nseg.pop_front();
    chk({tag, "_seg_count"}, act_segs.size(), n);
    for (int i = 0; i < n; i++) begin
      e = exp_segs.pop_front();
      chk($sformatf("%s_seg%0d", tag, i), (i < act_segs.size()) ? act_segs[i] : -1, e);
    end
    @(negedge clk);
    if (was_aborted) begin
      chk({tag, "_abort_single"}, int'(tx_aborted), 0);
    end else begin
      chk({tag, "_ready_after"}, int'(tx_ready), 1);
      chk({tag, "_low_after"}, int'(data_o), 0);
    end
  endtask

  int d, d2;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data_o", int'(data_o), 0);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(tx_done), 0);
    chk("rst_aborted", int'(tx_aborted), 0);
    rstn = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("idle_abort_ignored", int'(tx_aborted), 0);
    abort = 1'b0;
    @(negedge clk);

    run_frame("one_byte", 1'b0, 1, 32'h46, 1'b0, 0, 1'b0, 0, d);
`ifdef FCP_TX_CRC_EN
    chk("one_byte_latency", d, 720);
`else
    chk("one_byte_latency", d, 520);
`endif
    run_frame("ping_only", 1'b1, 2, 32'hA5A5, 1'b0, 0, 1'b0, 0, d);
    chk("ping_only_latency", d, 320);
    run_frame("len_zero", 1'b0, 0, 32'hFF, 1'b0, 0, 1'b0, 0, d);
    chk("len_zero_latency", d, 320);
    run_frame("tune_min", 1'b0, 1, 32'h5A, 1'b0, 18, 1'b0, 0, d);
    run_frame("tune_up3", 1'b0, 2, 32'h3CC3, 1'b1, 3, 1'b0, 0, d);
    run_frame("four_bytes", 1'b0, 4, 32'h01FF00A5, 1'b0, 0, 1'b0, 0, d);
    run_frame("len_clamp", 1'b0, 7, 32'h12345678, 1'b0, 10, 1'b0, 0, d);
    run_frame("abort_mid", 1'b0, 4, 32'h01FF00A5, 1'b0, 0, 1'b0, 450, d);
    run_frame("abort_last", 1'b1, 1, 32'h0, 1'b0, 0, 1'b0, 320, d);
    run_frame("b2b_first", 1'b0, 1, 32'h46, 1'b0, 0, 1'b1, 0, d);
    run_frame("b2b_second", 1'b0, 1, 32'h46, 1'b0, 0, 1'b0, 0, d2);
    chk("b2b_same_latency", d2, d);

    // asynchronous reset in the middle of a data bit
    tx_ping_only = 1'b0;
    tx_len       = LEN_W'(1);
    tx_payload   = 32'hFF;
    tune_up      = 1'b0;
    tune_cycle   = '0;
    tx_valid     = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) tx_valid = 1'b0;
    end
    chk("pre_reset_line", int'(data_o), 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_line", int'(data_o), 0);
    chk("async_rst_ready", int'(tx_ready), 1);
    chk("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_frame("post_reset", 1'b1, 0, 32'h0, 1'b0, 18, 1'b0, 0, d);
    chk("post_reset_latency", d, 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
